pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 108 ++++++++++
 tb/tb_pipe_adder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with optional accumulator and a delivered-result counter.
// Stage 0 does the arithmetic; the remaining LATENCY-1 stages only delay, all gated by one advance.
module pipe_adder #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic [15:0]      res_count
);

    logic [WIDTH-1:0] sum_q   [LATENCY];
    logic             carry_q [LATENCY];
    logic             ovf_q   [LATENCY];
    logic             valid_q [LATENCY];
    logic [WIDTH-1:0] acc_q;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   raw1;
    logic [WIDTH:0]   raw2;
    logic [WIDTH-1:0] part;
    logic             ovf1;
    logic             ovf2;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_ovf;

    assign advance  = out_ready || !valid_q[LATENCY-1];
    assign accept   = in_valid && advance;
    assign in_ready = advance;

    // First addition is A op B; with acc_en the accumulator is added to that partial result.
    always_comb begin
        op_b = sub ? ~b : b;
        raw1 = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, sub};
        part = raw1[WIDTH-1:0];
        ovf1 = (a[WIDTH-1] == op_b[WIDTH-1]) && (part[WIDTH-1] != a[WIDTH-1]);
        raw2 = {1'b0, acc_q} + {1'b0, part};
        ovf2 = (acc_q[WIDTH-1] == part[WIDTH-1]) && (raw2[WIDTH-1] != acc_q[WIDTH-1]);
        res_sum   = part;
        res_carry = raw1[WIDTH];
        res_ovf   = ovf1;
        if (acc_en) begin
            res_sum   = raw2[WIDTH-1:0];
            res_carry = raw2[WIDTH];
            res_ovf   = ovf1 | ovf2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                sum_q[i]   <= '0;
                carry_q[i] <= 1'b0;
                ovf_q[i]   <= 1'b0;
                valid_q[i] <= 1'b0;
            end
        end else if (advance) begin
            sum_q[0]   <= res_sum;
            carry_q[0] <= res_carry;
            ovf_q[0]   <= res_ovf;
            valid_q[0] <= accept;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                sum_q[i]   <= sum_q[i-1];
                carry_q[i] <= carry_q[i-1];
                ovf_q[i]   <= ovf_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Clear wins over an accumulate on the same edge; stage 0 above still saw the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            res_count <= '0;
        end else begin
            if (acc_clr) begin
                acc_q <= '0;
            end else if (accept && acc_en) begin
                acc_q <= res_sum;
            end
            if (valid_q[LATENCY-1] && out_ready) begin
                res_count <= res_count + 16'd1;
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign sum       = sum_q[LATENCY-1];
    assign carry     = carry_q[LATENCY-1];
    assign ovf       = ovf_q[LATENCY-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed vectors and corner sequences on an 8-bit/5-stage instance,
// plus randomized runs against an arithmetic reference model on several parameter sets.
module tb_pipe_adder;

    localparam int NI   = 3;
    localparam int LAT0 = 5;

    function automatic int w_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 1 : 32;
    endfunction

    function automatic int l_of(input int i);
        return (i == 0) ? 5 : (i == 1) ? 1 : 16;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [NI];
    logic        sub       [NI];
    logic        acc_en    [NI];
    logic        acc_clr   [NI];
    logic        out_ready [NI];
    logic [31:0] a         [NI];
    logic [31:0] b         [NI];
    logic        in_ready_w  [NI];
    logic        out_valid_w [NI];
    logic        carry_w     [NI];
    logic        ovf_w       [NI];
    logic [31:0] sum_w       [NI];
    logic [15:0] rc_w        [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = w_of(g);
        localparam int L = l_of(g);
        logic [W-1:0] s;
        pipe_adder #(.WIDTH(W), .LATENCY(L)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready_w[g]),
            .a        (a[g][W-1:0]),
            .b        (b[g][W-1:0]),
            .sub      (sub[g]),
            .acc_en   (acc_en[g]),
            .acc_clr  (acc_clr[g]),
            .out_valid(out_valid_w[g]),
            .out_ready(out_ready[g]),
            .sum      (s),
            .carry    (carry_w[g]),
            .ovf      (ovf_w[g]),
            .res_count(rc_w[g])
        );
        assign sum_w[g] = 32'(s);
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    typedef struct {
        longint s;
        bit     c;
        bit     o;
        longint adv;
    } exp_t;

    // Signed value of a w-bit pattern.
    function automatic longint sx(input longint v, input int w);
        longint half = longint'(1) << (w - 1);
        return (v >= half) ? v - (half << 1) : v;
    endfunction

    function automatic bit out_of_range(input longint v, input int w);
        longint half = longint'(1) << (w - 1);
        return (v >= half) || (v < -half);
    endfunction

    // Reference arithmetic from the signed/unsigned meaning of the operation.
    function automatic void model_op(input int w, input longint x, input longint av,
                                     input longint bv, input bit sb, input bit en,
                                     output longint s, output bit c, output bit o);
        longint m = longint'(1) << w;
        longint t;
        bit     c1;
        bit     v1;
        if (sb) begin
            t  = (av + m - bv) % m;
            c1 = av >= bv;
            v1 = out_of_range(sx(av, w) - sx(bv, w), w);
        end else begin
            t  = (av + bv) % m;
            c1 = (av + bv) >= m;
            v1 = out_of_range(sx(av, w) + sx(bv, w), w);
        end
        if (en) begin
            s = (x + t) % m;
            c = (x + t) >= m;
            o = v1 | out_of_range(sx(x, w) + sx(t, w), w);
        end else begin
            s = t;
            c = c1;
            o = v1;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            sub[i]       = 1'b0;
            acc_en[i]    = 1'b0;
            acc_clr[i]   = 1'b0;
            out_ready[i] = 1'b1;
            a[i]         = '0;
            b[i]         = '0;
        end
    endtask

    task automatic reset_all();
        step();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        step();
        in_valid[0] = 1'b1;
        a[0]        = 32'(v.a);
        b[0]        = 32'(v.b);
        sub[0]      = v.sub;
        acc_en[0]   = 1'b0;
        for (int k = 1; k <= LAT0 + 1; k++) begin
            step();
            in_valid[0] = 1'b0;
            #1;
            chk("vec_out_valid", longint'(out_valid_w[0]), longint'(k == LAT0));
            if (k == LAT0) begin
                chk("vec_sum", longint'(sum_w[0]), longint'(v.s));
                chk("vec_carry", longint'(carry_w[0]), longint'(v.c));
                chk("vec_ovf", longint'(ovf_w[0]), longint'(v.o));
            end
        end
    endtask

    task automatic rand_run(input int idx, input int n, input int rdy_pct);
        int     w = w_of(idx);
        int     l = l_of(idx);
        longint m = longint'(1) << w;
        exp_t   q[$];
        exp_t   e;
        longint acc = 0;
        longint adv = 0;
        longint rc  = 0;
        bit     mv;
        bit     advance;
        bit     accept;
        reset_all();
        for (int cyc = 0; cyc < n; cyc++) begin
            step();
            in_valid[idx]  = ($urandom_range(0, 3) != 0);
            a[idx]         = 32'(longint'($urandom) % m);
            b[idx]         = 32'(longint'($urandom) % m);
            sub[idx]       = $urandom_range(0, 1) == 1;
            acc_en[idx]    = $urandom_range(0, 3) == 0;
            acc_clr[idx]   = $urandom_range(0, 15) == 0;
            out_ready[idx] = $urandom_range(0, 99) < rdy_pct;
            #1;
            mv = 1'b0;
            if (q.size() > 0) mv = (adv - q[0].adv) == longint'(l - 1);
            chk("rnd_out_valid", longint'(out_valid_w[idx]), longint'(mv));
            if (mv) begin
                chk("rnd_sum", longint'(sum_w[idx]), q[0].s);
                chk("rnd_carry", longint'(carry_w[idx]), longint'(q[0].c));
                chk("rnd_ovf", longint'(ovf_w[idx]), longint'(q[0].o));
            end
            chk("rnd_res_count", longint'(rc_w[idx]), rc);
            advance = out_ready[idx] || !mv;
            chk("rnd_in_ready", longint'(in_ready_w[idx]), longint'(advance));
            accept = in_valid[idx] && advance;
            if (mv && out_ready[idx]) begin
                void'(q.pop_front());
                rc = (rc + 1) % 65536;
            end
            if (advance) adv++;
            if (accept) begin
                model_op(w, acc, longint'(a[idx]), longint'(b[idx]), sub[idx], acc_en[idx],
                         e.s, e.c, e.o);
                e.adv = adv;
                q.push_back(e);
            end
            if (acc_clr[idx]) acc = 0;
            else if (accept && acc_en[idx]) acc = e.s;
        end
        step();
        idle_inputs();
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] got[$];
        int          item;
        logic [31:0] acc_exp[5];

        vecs[0] = '{a: 8'h0F, b: 8'h01, sub: 1'b0, s: 8'h10, c: 1'b0, o: 1'b0};
        vecs[1] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: 8'h80, c: 1'b0, o: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, c: 1'b1, o: 1'b0};
        vecs[3] = '{a: 8'h00, b: 8'h01, sub: 1'b1, s: 8'hFF, c: 1'b0, o: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, s: 8'h7F, c: 1'b1, o: 1'b1};
        vecs[5] = '{a: 8'h05, b: 8'h03, sub: 1'b1, s: 8'h02, c: 1'b1, o: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h7F, sub: 1'b0, s: 8'hFE, c: 1'b0, o: 1'b1};
        vecs[7] = '{a: 8'h80, b: 8'h80, sub: 1'b0, s: 8'h00, c: 1'b1, o: 1'b1};
        acc_exp = '{32'd3, 32'd7, 32'd12, 32'd18, 32'd1};

        rst = 1'b1;
        idle_inputs();
        in_valid[0] = 1'b1;
        a[0]        = 32'h0F;
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", longint'(out_valid_w[i]), 0);
            chk("rst_sum", longint'(sum_w[i]), 0);
            chk("rst_carry", longint'(carry_w[i]), 0);
            chk("rst_ovf", longint'(ovf_w[i]), 0);
            chk("rst_res_count", longint'(rc_w[i]), 0);
            chk("rst_in_ready", longint'(in_ready_w[i]), 1);
        end
        in_valid[0] = 1'b0;
        rst = 1'b0;
        // Input offered during reset must never surface.
        for (int k = 0; k < LAT0 + 2; k++) begin
            step();
            chk("rst_no_accept", longint'(out_valid_w[0]), 0);
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Backpressure: 3-cycle stall while the first result sits at the output.
        reset_all();
        item = 1;
        for (int c = 0; c < 26; c++) begin
            step();
            out_ready[0] = !(c >= 5 && c <= 7);
            in_valid[0]  = item <= 4;
            a[0]         = 32'(item);
            b[0]         = '0;
            #1;
            if (c >= 5 && c <= 7) chk("bp_in_ready_stall", longint'(in_ready_w[0]), 0);
            if (c == 5) chk("bp_out_valid_at_stall", longint'(out_valid_w[0]), 1);
            if (out_valid_w[0] && out_ready[0]) got.push_back(sum_w[0]);
            if (in_valid[0] && in_ready_w[0]) item++;
        end
        chk("bp_count", longint'(got.size()), 4);
        for (int i = 0; i < got.size(); i++) chk("bp_order", longint'(got[i]), longint'(i + 1));
        chk("bp_res_count", longint'(rc_w[0]), 4);

        // Accumulate: clear, 3+4+5, then clear alongside a fourth accept.
        reset_all();
        got.delete();
        for (int c = 0; c < 20; c++) begin
            step();
            in_valid[0] = (c >= 1 && c <= 5);
            acc_en[0]   = (c >= 1 && c <= 5);
            acc_clr[0]  = (c == 0 || c == 4);
            sub[0]      = 1'b0;
            b[0]        = '0;
            a[0]        = (c == 1) ? 32'd3 : (c == 2) ? 32'd4 : (c == 3) ? 32'd5 :
                          (c == 4) ? 32'd6 : 32'd1;
            #1;
            if (out_valid_w[0] && out_ready[0]) got.push_back(sum_w[0]);
        end
        idle_inputs();
        chk("acc_count", longint'(got.size()), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk("acc_sum", longint'(got[i]), longint'(acc_exp[i]));

        // Asynchronous reset with three results in flight.
        reset_all();
        out_ready[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            in_valid[0] = c < 3;
            a[0]        = 32'(c + 20);
        end
        #1;
        chk("rmid_out_valid_before", longint'(out_valid_w[0]), 1);
        rst = 1'b1;
        #1;
        chk("rmid_out_valid_drop", longint'(out_valid_w[0]), 0);
        chk("rmid_sum", longint'(sum_w[0]), 0);
        chk("rmid_in_ready", longint'(in_ready_w[0]), 1);
        in_valid[0] = 1'b1;
        step();
        rst          = 1'b0;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("rmid_no_stale", longint'(out_valid_w[0]), 0);
        end
        chk("rmid_res_count", longint'(rc_w[0]), 0);

        rand_run(0, 400, 70);
        rand_run(1, 400, 50);
        rand_run(2, 400, 60);

        // Counter wrap on the single-stage, 1-bit instance.
        reset_all();
        in_valid[1] = 1'b1;
        for (int k = 0; k < 65536; k++) step();
        chk("wrap_ffff", longint'(rc_w[1]), 65535);
        step();
        chk("wrap_zero", longint'(rc_w[1]), 0);
        chk("wrap_streaming", longint'(out_valid_w[1]), 1);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
